div_dispatch: RTL and testbench

Execute-stage front end for the RV32M divide/remainder instructions, between the decoded execute-stage operands and the team's iterative 32-bit `div` block. It decodes DIV/DIVU/REM/REMU, registers stable operands and drives the divider's enable/signed handshake. It selects the quotient or remainder as the instruction result and stalls the pipeline while the divider works. A one-entry result cache lets a DIV/REM pair on identical operands finish the second instruction in one cycle. It also aborts cleanly on pipeline flush without leaving the divider mid-calculation.

---
 rtl/div_dispatch.sv | 140 ++++++++++++++
 tb/tb_div_dispatch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_dispatch.sv
// Execute-stage front end for RV32M DIV/DIVU/REM/REMU: drives the iterative divider,
// stalls execute while it works, and keeps a one-entry result cache for DIV/REM pairs.
`timescale 1ns/1ps
module div_dispatch #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] rs1_i,
    input  logic [N-1:0] rs2_i,
    input  logic         flush_i,
    output logic         hold_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         cache_hit_o,
    output logic         div_enable_o,
    output logic         div_signed_o,
    output logic [N-1:0] div_a_o,
    output logic [N-1:0] div_b_o,
    input  logic         div_hold_i,
    input  logic [N-1:0] div_quo_i,
    input  logic [N-1:0] div_rem_i
);

    typedef enum logic [2:0] {IDLE, RUN, DONE, DRAIN, CLR} state_t;

    state_t       state;
    logic         first;
    logic [1:0]   op_q;
    logic [N-1:0] a_q, b_q;
    logic         cvalid, csigned;
    logic [N-1:0] ca, cb, cquo, crem;
    logic         hit;

    assign hit = cvalid & valid_i & (rs1_i == ca) & (rs2_i == cb) & ((!op_i[0]) == csigned);

    assign div_a_o = a_q;
    assign div_b_o = b_q;

    // The divider only raises its hold one cycle after seeing enable, so its hold
    // is ignored during the first RUN cycle; enable is never dropped mid-calculation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            first        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cvalid       <= 1'b0;
            csigned      <= 1'b0;
            ca           <= '0;
            cb           <= '0;
            cquo         <= '0;
            crem         <= '0;
            div_enable_o <= 1'b0;
            div_signed_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && !flush_i && !hit) begin
                        a_q          <= rs1_i;
                        b_q          <= rs2_i;
                        op_q         <= op_i;
                        first        <= 1'b1;
                        div_enable_o <= 1'b1;
                        div_signed_o <= !op_i[0];
                        state        <= RUN;
                    end
                end
                RUN: begin
                    first <= 1'b0;
                    if (!div_hold_i && !first) begin
                        cvalid       <= 1'b1;
                        ca           <= a_q;
                        cb           <= b_q;
                        csigned      <= !op_q[0];
                        cquo         <= div_quo_i;
                        crem         <= div_rem_i;
                        div_enable_o <= 1'b0;
                        div_signed_o <= 1'b0;
                        state        <= flush_i ? CLR : DONE;
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                DONE: state <= IDLE;
                DRAIN: begin
                    if (!div_hold_i) begin
                        cvalid       <= 1'b1;
                        ca           <= a_q;
                        cb           <= b_q;
                        csigned      <= !op_q[0];
                        cquo         <= div_quo_i;
                        crem         <= div_rem_i;
                        div_enable_o <= 1'b0;
                        div_signed_o <= 1'b0;
                        state        <= CLR;
                    end
                end
                CLR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Hits and stalls must take effect in the accept cycle, so these outputs are decoded live.
    always_comb begin
        hold_o      = 1'b0;
        done_o      = 1'b0;
        cache_hit_o = 1'b0;
        result_o    = '0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (valid_i && !flush_i) begin
                        if (hit) begin
                            done_o      = 1'b1;
                            cache_hit_o = 1'b1;
                            result_o    = op_i[1] ? crem : cquo;
                        end else begin
                            hold_o = 1'b1;
                        end
                    end
                end
                RUN:  hold_o = 1'b1;
                DONE: begin
                    if (!flush_i) begin
                        done_o   = 1'b1;
                        result_o = op_q[1] ? crem : cquo;
                    end
                end
                DRAIN, CLR: hold_o = valid_i;
                default: hold_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_dispatch.sv
// Self-checking bench for div_dispatch: a behavioural iterative divider plus a
// reference model of results, cache hits and latency, with directed and random ops.
`timescale 1ns/1ps
module tb_div_dispatch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        flush = 1'b0;
    logic        hold, done, cache_hit, div_enable, div_signed, div_hold;
    logic [31:0] result, div_a, div_b, div_quo, div_rem;

    int compared = 0;
    int mismatched = 0;

    logic        m_valid = 1'b0, m_signed = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;

    always #5 clk = ~clk;

    div_dispatch #(.N(32)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
        .hold_o(hold), .done_o(done), .result_o(result), .cache_hit_o(cache_hit),
        .div_enable_o(div_enable), .div_signed_o(div_signed),
        .div_a_o(div_a), .div_b_o(div_b),
        .div_hold_i(div_hold), .div_quo_i(div_quo), .div_rem_i(div_rem)
    );

    function automatic logic is_trivial(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (b == 32'd1) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_quo(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        if (sgn) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [31:0] ref_rem(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return a;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        if (sgn) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    // Divider stand-in: hold rises the cycle after enable, 34 busy cycles for real
    // divides, none for trivial ones; dropping enable while busy freezes it.
    logic        dv_busy, dv_started;
    int          dv_cnt;
    logic [31:0] dv_q, dv_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dv_busy <= 1'b0; dv_started <= 1'b0; dv_cnt <= 0; dv_q <= '0; dv_r <= '0;
        end else if (div_enable) begin
            if (!dv_started) begin
                dv_started <= 1'b1;
                dv_q <= ref_quo(div_signed, div_a, div_b);
                dv_r <= ref_rem(div_signed, div_a, div_b);
                if (!is_trivial(div_signed, div_a, div_b)) begin
                    dv_busy <= 1'b1;
                    dv_cnt  <= 34;
                end
            end else if (dv_busy) begin
                if (dv_cnt == 1) dv_busy <= 1'b0;
                dv_cnt <= dv_cnt - 1;
            end
        end else if (!dv_busy) begin
            dv_started <= 1'b0;
        end
    end

    assign div_hold = dv_busy;
    assign div_quo  = (dv_started && !dv_busy) ? dv_q : 32'd0;
    assign div_rem  = (dv_started && !dv_busy) ? dv_r : 32'd0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Presents one op, waits for done and checks result, latency and hit against the model.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] got);
        logic        sgn, exp_hit, seen;
        int          exp_lat, lat, gaps;
        sgn     = !o[0];
        exp_hit = m_valid && m_a == a && m_b == b && m_signed == sgn;
        exp_lat = exp_hit ? 0 : (is_trivial(sgn, a, b) ? 3 : 37);
        valid = 1'b1; op = o; rs1 = a; rs2 = b; flush = 1'b0;
        seen = 1'b0; lat = 0; gaps = 0; got = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; lat = c; got = result;
                checkOutput({tag, "_hit"}, {31'd0, cache_hit}, {31'd0, exp_hit});
                checkOutput({tag, "_hold_at_done"}, {31'd0, hold}, 32'd0);
                break;
            end
            if (!hold) gaps++;
            @(posedge clk); #1;
        end
        checkOutput({tag, "_seen"}, {31'd0, seen}, 32'd1);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_result"}, got, o[1] ? ref_rem(sgn, a, b) : ref_quo(sgn, a, b));
        checkOutput({tag, "_hold_gaps"}, gaps, 32'd0);
        if (!exp_hit) begin
            m_valid = 1'b1; m_a = a; m_b = b; m_signed = sgn;
        end
        @(posedge clk); #1;
    endtask

    task automatic idleCycle(input string tag);
        valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_idle_result"}, result, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_hold"}, {31'd0, hold}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_result"}, result, 32'd0);
        checkOutput({tag, "_cache_hit"}, {31'd0, cache_hit}, 32'd0);
        checkOutput({tag, "_div_enable"}, {31'd0, div_enable}, 32'd0);
        checkOutput({tag, "_div_signed"}, {31'd0, div_signed}, 32'd0);
        checkOutput({tag, "_div_a"}, div_a, 32'd0);
        checkOutput({tag, "_div_b"}, div_b, 32'd0);
    endtask

    logic [31:0] got;
    logic [31:0] a_pool [6] = '{32'd1000, 32'hFFFF_FFEC, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd123456};
    logic [31:0] b_pool [6] = '{32'd0, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFF9};

    initial begin
        // Reset state
        valid = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd3;
        #2 checkAllZero("reset_init");
        valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        idleCycle("post_reset");

        // DIV -20/3 then REM hit on the next cycle
        applyStimulus("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, got);
        checkOutput("div_m20_3_const", got, 32'hFFFF_FFFA);
        applyStimulus("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, got);
        checkOutput("rem_m20_3_const", got, 32'hFFFF_FFFE);
        idleCycle("gap1");

        // Divide by zero, then REMU hit
        applyStimulus("divu_by0", 2'b01, 32'h8000_0000, 32'd0, got);
        checkOutput("divu_by0_const", got, 32'hFFFF_FFFF);
        applyStimulus("remu_by0", 2'b11, 32'h8000_0000, 32'd0, got);
        checkOutput("remu_by0_const", got, 32'h8000_0000);
        idleCycle("gap2");

        // Signed overflow, then REM hit
        applyStimulus("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, got);
        checkOutput("div_ovf_const", got, 32'h8000_0000);
        applyStimulus("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, got);
        checkOutput("rem_ovf_const", got, 32'd0);
        idleCycle("gap3");

        // Same operands, different signedness must miss
        applyStimulus("div_m1_2", 2'b00, 32'hFFFF_FFFF, 32'd2, got);
        checkOutput("div_m1_2_const", got, 32'd0);
        applyStimulus("divu_m1_2", 2'b01, 32'hFFFF_FFFF, 32'd2, got);
        checkOutput("divu_m1_2_const", got, 32'h7FFF_FFFF);

        // A would-be hit under flush is suppressed, then hits normally
        valid = 1'b1; op = 2'b01; rs1 = 32'hFFFF_FFFF; rs2 = 32'd2; flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_hit_done", {31'd0, done}, 32'd0);
        checkOutput("flush_hit_cache", {31'd0, cache_hit}, 32'd0);
        checkOutput("flush_hit_hold", {31'd0, hold}, 32'd0);
        @(posedge clk); #1;
        applyStimulus("hit_after_flush", 2'b11, 32'hFFFF_FFFF, 32'd2, got);
        idleCycle("gap4");

        // Abort and drain: DIV 1000/7 flushed at cycle 10, DIVU 100/7 from cycle 12
        begin
            int done_at = -1, early_done = 0, en_fall = -1;
            logic [31:0] drain_res = '0;
            logic hold11 = 1'b0, hold20 = 1'b0;
            for (int i = 0; i < 80; i++) begin
                valid = (i <= 10) || (i >= 12 && i <= 75);
                op    = (i <= 10) ? 2'b00 : 2'b01;
                rs1   = (i <= 10) ? 32'd1000 : 32'd100;
                rs2   = 32'd7;
                flush = (i == 10);
                @(negedge clk);
                if (done) begin
                    if (done_at < 0) begin done_at = i; drain_res = result; end
                    if (i < 75) early_done++;
                end
                if (i > 10 && !div_enable && en_fall < 0) en_fall = i;
                if (i == 11) hold11 = hold;
                if (i == 20) hold20 = hold;
                @(posedge clk); #1;
            end
            checkOutput("drain_no_early_done", early_done, 32'd0);
            checkOutput("drain_enable_fall", en_fall, 32'd37);
            checkOutput("drain_hold_c11", {31'd0, hold11}, 32'd0);
            checkOutput("drain_hold_c20", {31'd0, hold20}, 32'd1);
            checkOutput("drain_done_cycle", done_at, 32'd75);
            checkOutput("drain_result", drain_res, 32'd14);
            m_valid = 1'b1; m_a = 32'd100; m_b = 32'd7; m_signed = 1'b0;
        end
        idleCycle("gap5");

        // Reset in the middle of a miss
        valid = 1'b1; op = 2'b00; rs1 = 32'd12345; rs2 = 32'd67;
        repeat (20) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #1 checkAllZero("reset_mid");
        @(negedge clk) valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        applyStimulus("reissue_after_reset", 2'b00, 32'd12345, 32'd67, got);
        idleCycle("gap6");

        // Random ops from small pools so hits and trivial cases recur
        begin
            logic [31:0] ra = 32'd1, rb = 32'd1;
            for (int n = 0; n < 30; n++) begin
                if (n == 0 || $urandom_range(2) != 0) begin
                    ra = ($urandom_range(3) == 0) ? $urandom : a_pool[$urandom_range(5)];
                    rb = ($urandom_range(4) == 0) ? $urandom : b_pool[$urandom_range(5)];
                end
                applyStimulus("rnd", 2'($urandom_range(3)), ra, rb, got);
                if ($urandom_range(1) == 1) idleCycle("rnd_gap");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
